// File: rtl/fifo_write_arbiter_if.sv
// Producer-side and FIFO-write-side signals of the shared vertex FIFO write port.
// master drives requests and the full flag; slave is the arbiter.
interface fifo_write_arbiter_if #(
    parameter int DBITS = 96,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*DBITS-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    fifo_full;
    logic                    fifo_wr;
    logic [DBITS-1:0]        fifo_din;
    logic                    busy;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic [15:0]             prim_count;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_din, busy, grant_id, prim_count
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_din, busy, grant_id, prim_count
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-atomic sharing of one FIFO write port; 1 cycle arbitration, then 1 beat/cycle.
// A grantee stall or fifo_full holds the grant and all state; no beat is written while full.
module fifo_write_arbiter #(
    parameter int DBITS = 96,
    parameter int NREQ  = 4,
    parameter int BURST = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_write_arbiter_if.slave   bus
);
    localparam int GW = $clog2(NREQ);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [15:0]     prim_q, prim_d;
    logic [GW-1:0]   pick;
    logic [GW:0]     cand_sum;
    logic            any_vld;
    logic            in_burst;
    logic            xfer;
    logic [NREQ-1:0] ready;

    assign any_vld  = |bus.req_valid;
    assign in_burst = (state_q == ST_BURST);
    // Gated by reset so nothing is written or acknowledged during the reset cycle.
    assign xfer     = reset & in_burst & bus.req_valid[grant_q] & ~bus.fifo_full;

    // Descending scan: the nearest valid requester after the current grantee wins last.
    always_comb begin
        pick     = grant_q;
        cand_sum = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_sum = {1'b0, grant_q} + (GW + 1)'(k);
            if (cand_sum >= (GW + 1)'(NREQ)) begin
                cand_sum = cand_sum - (GW + 1)'(NREQ);
            end
            if (bus.req_valid[cand_sum[GW-1:0]]) begin
                pick = cand_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (xfer) begin
            ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        prim_d  = prim_q;
        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    state_d = ST_BURST;
                    grant_d = pick;
                    beat_d  = '0;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    if (beat_q == LAST_BEAT) begin
                        prim_d = prim_q + 16'd1;
                        beat_d = '0;
                        if (any_vld) begin
                            grant_d = pick;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= GW'(NREQ - 1);
            beat_q  <= '0;
            prim_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            prim_q  <= prim_d;
        end
    end

    assign bus.fifo_wr    = xfer;
    assign bus.req_ready  = ready;
    assign bus.fifo_din   = bus.req_data[int'(grant_q) * DBITS +: DBITS];
    assign bus.busy       = reset & in_burst;
    assign bus.grant_id   = grant_q;
    assign bus.prim_count = prim_q;
endmodule
